// File: rtl/arcade_input_ctrl.sv
// Player control front end for the galaxian core: PS/2 key decode, joystick merge,
// orientation remap, autofire and a timed coin/start sequencer. All outputs registered.
module arcade_input_ctrl #(
   parameter int CLK_HZ  = 12000000,
   parameter int COIN_MS = 100,
   parameter int GAP_MS  = 200,
   parameter int AF_MS   = 50
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [64:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   input  logic        autofire_en,
   output logic [6:0]  P1_CSJUDLR,
   output logic [6:0]  P2_CSJUDLR,
   output logic        coin_busy
);

   localparam int DIV   = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, COIN, GAP, WAIT_REL} state_t;

   logic              toggle_p0;
   logic              key_evt_p0, key_pressed_p0, key_ext_p0;
   logic [8:0]        key_code_p0;
   logic              k_up_p1, k_down_p1, k_left_p1, k_right_p1;
   logic              k_fire_p1, k_s1_p1, k_s2_p1;
   logic [15:0]       j;
   logic              raw_up, raw_down, raw_left, raw_right;
   logic              raw_fire, raw_s1, raw_s2, start_raw, start_rise;
   logic              fire_out;
   logic [PRE_W-1:0]  pre_cnt;
   logic              tick;
   logic [CNT_W-1:0]  af_cnt;
   logic              af_phase;
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  seq_cnt, seq_cnt_nxt;
   logic              start_d;
   logic              coin_nxt, pass_nxt, busy_nxt;
   logic              unused_j;

   // Stage p0: key event decode
   always_comb begin
      key_evt_p0     = (ps2_key[64] != toggle_p0);
      key_pressed_p0 = (ps2_key[15:8] != 8'hF0);
      key_ext_p0     = key_pressed_p0 ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
      key_code_p0    = (ps2_key[63:24] != '0) ? 9'h000 : {key_ext_p0, ps2_key[7:0]};
   end

   // Stage p1: key latches
   always_ff @(posedge clk_sys) begin
      toggle_p0 <= ps2_key[64];
      if (reset) begin
         k_up_p1    <= 1'b0;
         k_down_p1  <= 1'b0;
         k_left_p1  <= 1'b0;
         k_right_p1 <= 1'b0;
         k_fire_p1  <= 1'b0;
         k_s1_p1    <= 1'b0;
         k_s2_p1    <= 1'b0;
      end else if (key_evt_p0) begin
         // Cursor keys arrive both plain and E0-prefixed, so the extended bit is ignored
         case (key_code_p0[7:0])
            8'h75:   k_up_p1    <= key_pressed_p0;
            8'h72:   k_down_p1  <= key_pressed_p0;
            8'h6B:   k_left_p1  <= key_pressed_p0;
            8'h74:   k_right_p1 <= key_pressed_p0;
            default: ;
         endcase
         case (key_code_p0)
            9'h029, 9'h014: k_fire_p1 <= key_pressed_p0;
            9'h005:         k_s1_p1   <= key_pressed_p0;
            9'h006:         k_s2_p1   <= key_pressed_p0;
            default:        ;
         endcase
      end
   end

   always_comb begin
      j = joystick_0 | joystick_1;
      if (rotate) begin
         raw_up    = k_left_p1  | j[1];
         raw_down  = k_right_p1 | j[0];
         raw_left  = k_down_p1  | j[2];
         raw_right = k_up_p1    | j[3];
      end else begin
         raw_up    = k_up_p1    | j[3];
         raw_down  = k_down_p1  | j[2];
         raw_left  = k_left_p1  | j[1];
         raw_right = k_right_p1 | j[0];
      end
      raw_fire   = k_fire_p1 | j[4];
      raw_s1     = k_s1_p1   | j[5];
      raw_s2     = k_s2_p1   | j[6];
      start_raw  = raw_s1 | raw_s2;
      start_rise = start_raw & ~start_d;
      tick       = (pre_cnt == PRE_W'(DIV - 1));
      fire_out   = (autofire_en && raw_fire) ? af_phase : raw_fire;
   end

   assign unused_j = ^j[15:7];

   always_ff @(posedge clk_sys) begin
      if (reset)     pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + PRE_W'(1);
   end

   // Phase idles at 1 so the first shot lands on the same cycle fire is pressed
   always_ff @(posedge clk_sys) begin
      if (reset || !autofire_en || !raw_fire) begin
         af_phase <= 1'b1;
         af_cnt   <= '0;
      end else if (tick) begin
         if (af_cnt == CNT_W'(AF_MS - 1)) begin
            af_phase <= ~af_phase;
            af_cnt   <= '0;
         end else begin
            af_cnt <= af_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      seq_cnt_nxt = seq_cnt;
      case (state)
         IDLE: begin
            if (start_rise) begin
               state_nxt   = COIN;
               seq_cnt_nxt = '0;
            end
         end
         COIN: begin
            if (tick) begin
               if (seq_cnt == CNT_W'(COIN_MS - 1)) begin
                  state_nxt   = GAP;
                  seq_cnt_nxt = '0;
               end else begin
                  seq_cnt_nxt = seq_cnt + CNT_W'(1);
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (seq_cnt == CNT_W'(GAP_MS - 1)) begin
                  state_nxt   = WAIT_REL;
                  seq_cnt_nxt = '0;
               end else begin
                  seq_cnt_nxt = seq_cnt + CNT_W'(1);
               end
            end
         end
         WAIT_REL: begin
            if (!raw_s1 && !raw_s2) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Outputs follow the next state so they line up with the registered state
      coin_nxt = (state_nxt == COIN);
      pass_nxt = (state_nxt == WAIT_REL);
      busy_nxt = (state_nxt == COIN) || (state_nxt == GAP);
   end

   // Stage p2: sequencer state and output registers
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         seq_cnt    <= '0;
         start_d    <= 1'b0;
         P1_CSJUDLR <= 7'b0;
         P2_CSJUDLR <= 7'b0;
         coin_busy  <= 1'b0;
      end else begin
         state      <= state_nxt;
         seq_cnt    <= seq_cnt_nxt;
         start_d    <= start_raw;
         P1_CSJUDLR <= {coin_nxt, raw_s1 & pass_nxt, fire_out, raw_up, raw_down, raw_left, raw_right};
         P2_CSJUDLR <= {1'b0, raw_s2 & pass_nxt, fire_out, raw_up, raw_down, raw_left, raw_right};
         coin_busy  <= busy_nxt;
      end
   end

endmodule
